// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the register file: zero-clears every entry after reset
// or on request, then arbitrates two writers round-robin onto one registered write port.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  input  logic [DATA_W-1:0] i_req0_data,
  output logic              o_req0_ready,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req1_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_init_done,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LP_LAST_ADDR = '1;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_last;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_busy;
  logic                r_init_done;

  logic                w_open;
  logic                w_gnt0;
  logic                w_gnt1;

  // Handshake: a write transfers on a rising edge where valid and ready are both high;
  // a requester must hold valid, addr and data stable until it sees ready.
  // r_last is 1 when requester 1 won the most recent transfer, so ties go to the other one.
  assign w_open = (r_state == ST_RUN) && !i_init;
  assign w_gnt0 = w_open && i_req0_valid && (!i_req1_valid || r_last);
  assign w_gnt1 = w_open && i_req1_valid && (!i_req0_valid || !r_last);

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;
  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_busy       = r_busy;
  assign o_init_done  = r_init_done;
  assign o_dbg_state  = (r_state == ST_RUN);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_cnt;
          r_wr_data <= '0;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == LP_LAST_ADDR) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b0;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_init) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_wr_en <= 1'b0;
          end else if (w_gnt0) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= i_req0_addr;
            r_wr_data <= i_req0_data;
            r_last    <= 1'b0;
          end else if (w_gnt1) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= i_req1_addr;
            r_wr_data <= i_req1_data;
            r_last    <= 1'b1;
          end else begin
            r_wr_en <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a cycle-level reference model predicts
// readies, the write stream and busy/init_done; a negedge monitor compares DUT outputs.
module tb_regfile_write_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam int EW   = AW + DW;

  // clock / reset
  logic          i_clk;
  logic          i_rst_n;
  logic          i_init;
  logic          i_req0_valid, i_req1_valid;
  logic [AW-1:0] i_req0_addr, i_req1_addr;
  logic [DW-1:0] i_req0_data, i_req1_data;
  logic          o_req0_ready, o_req1_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_busy, o_init_done, o_dbg_state;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_init(i_init),
    .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data),
    .o_req0_ready(o_req0_ready),
    .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data),
    .o_req1_ready(o_req1_ready),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_busy(o_busy), .o_init_done(o_init_done), .o_dbg_state(o_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard queues: expected writes {addr,data}; expected status {wr_en,busy,init_done}
  logic [EW-1:0] exp_q[$];
  logic [2:0]    st_q[$];
  logic [DW-1:0] rf [NREG];

  // reference model state
  bit m_clear;
  int m_left;
  int m_last;
  int m_gnt;

  // requester stimulus state
  bit            p_v0, p_v1;
  logic [AW-1:0] p_a0, p_a1, fa0, fa1;
  logic [DW-1:0] p_d0, p_d1, fd0, fd1;
  int            gen0, gen1;
  int            init_rate;
  bit            init_once;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1'b1;
    m_left  = NREG;
    m_last  = 1;
    exp_q.delete();
    st_q.delete();
  endtask

  task automatic check_reset();
    check("rst_wr_en", 64'(o_wr_en), 64'(0));
    check("rst_wr_addr", 64'(o_wr_addr), 64'(0));
    check("rst_wr_data", 64'(o_wr_data), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(1));
    check("rst_init_done", 64'(o_init_done), 64'(0));
    check("rst_ready0", 64'(o_req0_ready), 64'(0));
    check("rst_ready1", 64'(o_req1_ready), 64'(0));
  endtask

  // One cycle of the reference model, evaluated after inputs settle and before the edge.
  task automatic step();
    #1;
    m_gnt = -1;
    if (m_clear) begin
      check("clr_ready0", 64'(o_req0_ready), 64'(0));
      check("clr_ready1", 64'(o_req1_ready), 64'(0));
      exp_q.push_back({AW'(NREG - m_left), DW'(0)});
      m_left--;
      if (m_left == 0) begin
        m_clear = 1'b0;
        st_q.push_back(3'b101);
      end else begin
        st_q.push_back(3'b110);
      end
    end else if (i_init) begin
      check("init_ready0", 64'(o_req0_ready), 64'(0));
      check("init_ready1", 64'(o_req1_ready), 64'(0));
      m_clear = 1'b1;
      m_left  = NREG;
      st_q.push_back(3'b010);
    end else begin
      if (p_v0 && p_v1) m_gnt = (m_last == 1) ? 0 : 1;
      else if (p_v0)    m_gnt = 0;
      else if (p_v1)    m_gnt = 1;
      check("ready0", 64'(o_req0_ready), 64'(m_gnt == 0));
      check("ready1", 64'(o_req1_ready), 64'(m_gnt == 1));
      if (m_gnt == 0) exp_q.push_back({p_a0, p_d0});
      if (m_gnt == 1) exp_q.push_back({p_a1, p_d1});
      if (m_gnt >= 0) m_last = m_gnt;
      st_q.push_back({m_gnt >= 0, 2'b00});
    end
  endtask

  // driver: one call per cycle, inputs change on the falling edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      if (!p_v0 && gen0 == 1) begin p_v0 = 1'b1; p_a0 = fa0; p_d0 = fd0; end
      if (!p_v1 && gen1 == 1) begin p_v1 = 1'b1; p_a1 = fa1; p_d1 = fd1; end
      if (!p_v0 && gen0 == 2 && $urandom_range(0, 2) == 0) begin
        p_v0 = 1'b1; p_a0 = AW'($urandom); p_d0 = $urandom;
      end
      if (!p_v1 && gen1 == 2 && $urandom_range(0, 2) == 0) begin
        p_v1 = 1'b1; p_a1 = AW'($urandom); p_d1 = $urandom;
      end
      i_init = init_once || (init_rate > 0 && $urandom_range(1, init_rate) == 1);
      init_once = 1'b0;
      i_req0_valid = p_v0; i_req0_addr = p_a0; i_req0_data = p_d0;
      i_req1_valid = p_v1; i_req1_addr = p_a1; i_req1_data = p_d1;
      step();
      if (m_gnt == 0) p_v0 = 1'b0;
      if (m_gnt == 1) p_v1 = 1'b0;
    end
  endtask

  // monitor
  logic [2:0]    mon_s;
  logic [EW-1:0] mon_e;
  always @(negedge i_clk) begin
    if (i_rst_n && st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      check("wr_en", 64'(o_wr_en), 64'(mon_s[2]));
      check("busy", 64'(o_busy), 64'(mon_s[1]));
      check("init_done", 64'(o_init_done), 64'(mon_s[0]));
      if (o_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(o_wr_addr), 64'(mon_e[EW-1:DW]));
          check("wr_data", 64'(o_wr_data), 64'(mon_e[DW-1:0]));
        end
        rf[o_wr_addr] = o_wr_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b1; i_init = 1'b0;
    i_req0_valid = 1'b0; i_req0_addr = '0; i_req0_data = '0;
    i_req1_valid = 1'b0; i_req1_addr = '0; i_req1_data = '0;
    p_v0 = 1'b0; p_v1 = 1'b0; p_a0 = '0; p_a1 = '0; p_d0 = '0; p_d1 = '0;
    gen0 = 0; gen1 = 0; init_rate = 0; init_once = 1'b0;
    fa0 = '0; fa1 = '0; fd0 = '0; fd1 = '0;
    for (int i = 0; i < NREG; i++) rf[i] = 32'hDEAD_BEEF;
    model_reset();

    #2 i_rst_n = 1'b0;
    #1 check_reset();
    repeat (3) @(posedge i_clk);
    #2 i_rst_n = 1'b1;

    // both requesters streaming from the first RUN cycle
    fa0 = 5'h0B; fd0 = 32'hABCDEF89; fa1 = 5'h0C; fd1 = 32'h11111111;
    gen0 = 1; gen1 = 1;
    run(NREG + 10);
    gen0 = 0; gen1 = 0;
    run(3);

    // single write from requester 0
    p_v0 = 1'b1; p_a0 = 5'h03; p_d0 = 32'h01234567;
    run(3);
    // single write from requester 1 leaves the pointer at requester 1
    p_v1 = 1'b1; p_a1 = 5'h07; p_d1 = $urandom;
    run(2);
    // same destination from both
    p_v0 = 1'b1; p_a0 = 5'h05; p_d0 = 32'hAAAA0000;
    p_v1 = 1'b1; p_a1 = 5'h05; p_d1 = 32'h5555FFFF;
    run(4);
    check("rf5_last_writer", 64'(rf[5]), 64'(32'h5555FFFF));
    check("rf3_single", 64'(rf[3]), 64'(32'h01234567));

    // init while requester 1 is waiting
    p_v1 = 1'b1; p_a1 = 5'h1F; p_d1 = $urandom;
    init_once = 1'b1;
    run(NREG + 4);
    check("rf31_after_init", 64'(rf[31]), 64'(p_d1));

    // random traffic with occasional init
    gen0 = 2; gen1 = 2; init_rate = 60;
    run(300);
    gen0 = 0; gen1 = 0; init_rate = 0;
    run(NREG + 6);

    // reset in the middle of a clear
    init_once = 1'b1;
    run(1);
    for (int i = 0; i < 100 && !(m_clear && m_left == NREG - 17); i++) run(1);
    check("reached_clear_0x10", 64'(m_clear && m_left == NREG - 17), 64'(1));
    @(posedge i_clk);
    #2;
    check("pre_rst_addr", 64'(o_wr_addr), 64'(5'h10));
    i_rst_n = 1'b0;
    #1 check_reset();
    model_reset();
    p_v0 = 1'b0; p_v1 = 1'b0;
    i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_init = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_rst_n = 1'b1;
    run(NREG + 4);

    @(negedge i_clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("st_q_drained", 64'(st_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
